// File: rtl/stream_fifo_arbiter.sv
// Round-robin burst arbiter: NUM_IN AXI-Stream producers share one FIFO input port.
// Latency: grant 1 cycle after a request is seen in IDLE; data path is combinational (0 cycles).
// Backpressure: out_TREADY passes straight to the granted producer; a burst is granted only if the FIFO has room for all of it.
//
// Ports:
//   ap_clk, ap_rst           clock, asynchronous active-high reset
//   in_TDATA/TVALID/TREADY   NUM_IN producer streams (stream i at in_TDATA[i*WIDTH +: WIDTH])
//   out_TDATA/TVALID/TREADY  single stream towards the FIFO in0 port
//   fifo_count               FIFO occupancy, used for the space check
//   grant_idx                current or last granted stream (zero-extended)
//   busy                     high while a burst is in progress
//   err                      sticky stall-timeout flag
//
// Optional feature macro: STREAM_ARB_TIMEOUT_EN
//   defined   : a burst whose producer stalls for TIMEOUT cycles is aborted and err is set
//   undefined : bursts wait indefinitely, err is tied to 0

module stream_fifo_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int WIDTH      = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 2048,
  parameter int COUNT_W    = 11,
  parameter int SLACK      = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_IN*WIDTH-1:0] in_TDATA,
  input  logic [NUM_IN-1:0]       in_TVALID,
  output logic [NUM_IN-1:0]       in_TREADY,
  output logic [WIDTH-1:0]        out_TDATA,
  output logic                    out_TVALID,
  input  logic                    out_TREADY,
  input  logic [COUNT_W-1:0]      fifo_count,
  output logic [2:0]              grant_idx,
  output logic                    busy,
  output logic                    err
);

  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  // Wide enough that count + BURST_LEN + SLACK can never wrap.
  localparam int SUM_W  = COUNT_W + 33;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant;

  logic [SUM_W-1:0]    w_need;
  logic                w_space;
  logic [IDX_W-1:0]    w_cand;
  logic [IDX_W-1:0]    w_sel;
  logic                w_any;
  logic                w_start;
  logic                w_beat;
  logic                w_last;
  logic                w_abort;

  // ---------------------------------------------------------------------------
  // Space check: the whole burst plus reporting slack must fit.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_need  = SUM_W'(fifo_count) + SUM_W'(BURST_LEN) + SUM_W'(SLACK);
    w_space = (w_need <= SUM_W'(FIFO_DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid stream after r_rr_ptr, wrapping modulo NUM_IN.
  // r_rr_ptr itself is examined last, so the previous winner only repeats when
  // no other stream is requesting.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_rr_ptr;
    w_cand = r_rr_ptr;
    for (int i = 1; i <= NUM_IN; i++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_IN);
      if (!w_any && in_TVALID[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_start = (r_state == S_IDLE) && w_any && w_space;
  assign w_beat  = (r_state == S_BURST) && out_TVALID && out_TREADY;
  assign w_last  = w_beat && (r_beat_cnt == BCNT_W'(BURST_LEN - 1));

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_err;

  // Abort on the edge where the stall count would reach TIMEOUT, so the
  // arbiter is back in IDLE exactly TIMEOUT stalled cycles after the last beat.
  assign w_abort = (r_state == S_BURST) && !in_TVALID[r_grant] &&
                   (r_stall == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state != S_BURST || w_beat || w_abort) begin
        r_stall <= '0;
      end else if (!in_TVALID[r_grant]) begin
        r_stall <= r_stall + 1'b1;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_BURST;
        end
      end
      S_BURST: begin
        // Returning to IDLE after the last beat gives the one-cycle bubble in
        // which the next winner is chosen.
        if (w_last || w_abort) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Pure pass-through from the granted stream while in BURST;
  // everything parked at zero in IDLE so out_TDATA is never X.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_TDATA  = '0;
    out_TVALID = 1'b0;
    in_TREADY  = '0;
    if (r_state == S_BURST) begin
      out_TDATA           = in_TDATA[int'(r_grant)*WIDTH +: WIDTH];
      out_TVALID          = in_TVALID[r_grant];
      in_TREADY[r_grant]  = out_TREADY;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping and beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_beat_cnt <= '0;
      r_rr_ptr   <= IDX_W'(NUM_IN - 1);
      r_grant    <= '0;
    end else begin
      if (w_start) begin
        r_grant    <= w_sel;
        r_rr_ptr   <= w_sel;
        r_beat_cnt <= '0;
      end else if (w_last || w_abort) begin
        // r_rr_ptr already holds the granted stream, so an aborted stream is
        // searched last at the next decision.
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign busy      = (r_state == S_BURST);
  assign grant_idx = 3'(r_grant);

endmodule
